// File: rtl/mutex_arbiter.sv
// Two-requester mutex arbiter. A grant lasts until the owner releases it,
// drops its request, or holds it for MAX_HOLD cycles. Each grant is followed
// by a forced all-idle gap. When both requesters ask at once, the one that
// did not own the most recent grant wins.
module mutex_arbiter #(
    parameter int MAX_HOLD    = 8,   // 1..255
    parameter int DEAD_CYCLES = 1    // 0..15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    // Release strobe, one bit per requester ("release" is a reserved word)
    input  logic [1:0] release_pulse,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       timeout,
    output logic       last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [3:0] DEAD_LEN = 4'(DEAD_CYCLES);

    state_t     state;
    logic [7:0] hold;
    logic [3:0] dead_cnt;

    logic owner;       // index of the current owner (valid in OWN0/OWN1)
    logic own_req;
    logic own_rel;
    logic expired;
    logic end_grant;
    logic pick;        // requester to grant from IDLE

    // Grant-end conditions look only at the owner's bits; the other
    // requester cannot influence a running grant.
    always_comb begin
        owner     = (state == OWN1);
        own_req   = req[owner];
        own_rel   = release_pulse[owner];
        expired   = (hold == HOLD_MAX);
        end_grant = ((state == OWN0) || (state == OWN1)) &&
                    (own_rel || !own_req || expired);
        pick      = (req == 2'b11) ? ~last : req[1];
    end

    // Arbiter FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            last     <= 1'b1;
            hold     <= 8'd0;
            dead_cnt <= 4'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state <= pick ? OWN1 : OWN0;
                        gnt   <= pick ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        hold  <= 8'd1;
                    end
                end
                OWN0, OWN1: begin
                    if (end_grant) begin
                        last    <= owner;
                        gnt     <= 2'b00;
                        hold    <= 8'd0;
                        // Pulse only for a pure expiry: the owner still wanted
                        // the resource and did not give it back itself.
                        timeout <= expired && !own_rel && own_req;
                        if (DEAD_LEN != 4'd0) begin
                            state    <= DEAD;
                            busy     <= 1'b1;
                            dead_cnt <= 4'd1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                DEAD: begin
                    if (dead_cnt >= DEAD_LEN) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        dead_cnt <= 4'd0;
                    end else begin
                        dead_cnt <= dead_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mutex_arbiter.sv
// Directed bench for mutex_arbiter: a vector table on a MAX_HOLD=4 /
// DEAD_CYCLES=1 instance plus a hand sequence on a DEAD_CYCLES=0 instance,
// with per-cycle invariant checks on both.
module tb_mutex_arbiter;

    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic [1:0] rel;
        logic [1:0] gnt;
        logic       busy;
        logic       to;
        logic       last;
    } vec_t;

    logic       clk = 1'b0;
    logic       a_rst = 1'b1, b_rst = 1'b1;
    logic [1:0] a_req = 2'b00, a_rel = 2'b00, b_req = 2'b00, b_rel = 2'b00;
    logic [1:0] a_gnt, b_gnt;
    logic       a_busy, a_to, a_last, b_busy, b_to, b_last;

    int passed = 0;
    int total  = 0;
    logic chk_en = 1'b0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mutex_arbiter #(.MAX_HOLD(4), .DEAD_CYCLES(1)) dut_a (
        .clock(clk), .reset(a_rst), .req(a_req), .release_pulse(a_rel),
        .gnt(a_gnt), .busy(a_busy), .timeout(a_to), .last(a_last)
    );

    mutex_arbiter #(.MAX_HOLD(4), .DEAD_CYCLES(0)) dut_b (
        .clock(clk), .reset(b_rst), .req(b_req), .release_pulse(b_rel),
        .gnt(b_gnt), .busy(b_busy), .timeout(b_to), .last(b_last)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] rl,
                       input logic [1:0] g, input logic b, input logic t, input logic l);
        vecs.push_back('{rst: r, req: rq, rel: rl, gnt: g, busy: b, to: t, last: l});
    endtask

    task automatic step_b(input int n, input logic r, input logic [1:0] rq, input logic [1:0] rl,
                          input logic [1:0] g, input logic b, input logic t, input logic l);
        b_rst = r; b_req = rq; b_rel = rl;
        @(posedge clk); #1;
        chk($sformatf("b%0d gnt", n),  {6'd0, b_gnt},  {6'd0, g});
        chk($sformatf("b%0d busy", n), {7'd0, b_busy}, {7'd0, b});
        chk($sformatf("b%0d to", n),   {7'd0, b_to},   {7'd0, t});
        chk($sformatf("b%0d last", n), {7'd0, b_last}, {7'd0, l});
    endtask

    // Invariants every cycle: never a double grant, busy tracks non-IDLE.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a onehot", {7'd0, a_gnt == 2'b11}, 8'd0);
            chk("b onehot", {7'd0, b_gnt == 2'b11}, 8'd0);
            chk("a busy_state", {7'd0, a_busy}, {7'd0, dut_a.state != 2'd0});
            chk("b busy_state", {7'd0, b_busy}, {7'd0, dut_b.state != 2'd0});
        end
    end

    initial begin
        //   rst req    rel    gnt    busy to last
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 1);  // 0 reset
        add(1, 2'b11, 2'b00, 2'b00, 0, 0, 1);  // 1 reset beats requests
        add(0, 2'b11, 2'b00, 2'b01, 1, 0, 1);  // 2 tie -> 0 (last=1)
        add(0, 2'b11, 2'b00, 2'b01, 1, 0, 1);  // 3
        add(0, 2'b11, 2'b01, 2'b00, 1, 0, 0);  // 4 release -> DEAD
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 0);  // 5 IDLE
        add(0, 2'b11, 2'b00, 2'b10, 1, 0, 0);  // 6 tie -> 1
        add(0, 2'b11, 2'b00, 2'b10, 1, 0, 0);  // 7
        add(0, 2'b11, 2'b10, 2'b00, 1, 0, 1);  // 8 release -> DEAD
        add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1);  // 9
        add(0, 2'b11, 2'b00, 2'b01, 1, 0, 1);  // 10 tie -> 0
        add(0, 2'b11, 2'b10, 2'b01, 1, 0, 1);  // 11 non-owner release ignored
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 1);  // 12 hold 3
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 1);  // 13 hold 4
        add(0, 2'b01, 2'b00, 2'b00, 1, 1, 0);  // 14 expiry -> timeout
        add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0);  // 15
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 16 hold 1
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 17
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 18
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 19 hold 4
        add(0, 2'b01, 2'b00, 2'b00, 1, 1, 0);  // 20 timeout
        add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0);  // 21
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 22 regrant
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 23
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 24
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 0);  // 25 hold 4
        add(0, 2'b01, 2'b01, 2'b00, 1, 0, 0);  // 26 release at expiry: no timeout
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 0);  // 27
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 0);  // 28 idle stays idle
        add(0, 2'b10, 2'b00, 2'b10, 1, 0, 0);  // 29 single req 1
        add(0, 2'b00, 2'b00, 2'b00, 1, 0, 1);  // 30 req drop ends grant
        add(0, 2'b10, 2'b00, 2'b00, 0, 0, 1);  // 31 DEAD ignores req
        add(0, 2'b10, 2'b00, 2'b10, 1, 0, 1);  // 32 hold 1
        add(0, 2'b10, 2'b00, 2'b10, 1, 0, 1);  // 33 hold 2
        add(0, 2'b10, 2'b00, 2'b10, 1, 0, 1);  // 34 hold 3
        add(1, 2'b10, 2'b00, 2'b00, 0, 0, 1);  // 35 reset mid-grant
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 1);  // 36
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 1);  // 37
        add(0, 2'b01, 2'b01, 2'b00, 1, 0, 0);  // 38 DEAD
        add(1, 2'b01, 2'b00, 2'b00, 0, 0, 1);  // 39 reset mid-DEAD restores last
        add(0, 2'b11, 2'b00, 2'b01, 1, 0, 1);  // 40

        foreach (vecs[i]) begin
            a_rst = vecs[i].rst; a_req = vecs[i].req; a_rel = vecs[i].rel;
            @(posedge clk); #1;
            chk_en = 1'b1;
            chk($sformatf("a%0d gnt", i),  {6'd0, a_gnt},  {6'd0, vecs[i].gnt});
            chk($sformatf("a%0d busy", i), {7'd0, a_busy}, {7'd0, vecs[i].busy});
            chk($sformatf("a%0d to", i),   {7'd0, a_to},   {7'd0, vecs[i].to});
            chk($sformatf("a%0d last", i), {7'd0, a_last}, {7'd0, vecs[i].last});
        end

        // No dead gap: a grant end is followed by exactly one idle cycle.
        step_b(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        step_b(1, 0, 2'b01, 2'b00, 2'b01, 1, 0, 1);
        step_b(2, 0, 2'b01, 2'b00, 2'b01, 1, 0, 1);
        step_b(3, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        step_b(4, 0, 2'b10, 2'b00, 2'b10, 1, 0, 0);
        step_b(5, 0, 2'b10, 2'b00, 2'b10, 1, 0, 0);
        step_b(6, 0, 2'b10, 2'b00, 2'b10, 1, 0, 0);
        step_b(7, 0, 2'b10, 2'b00, 2'b10, 1, 0, 0);
        step_b(8, 0, 2'b10, 2'b00, 2'b00, 0, 1, 1);
        step_b(9, 0, 2'b10, 2'b00, 2'b10, 1, 0, 1);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
